mux_nx1_pipe: RTL and testbench

//  Parametrised N:1 datapath multiplexer with one registered output stage and a

---
 rtl/mux_nx1_pipe_if.sv | 25 ++
 rtl/mux_nx1_pipe.sv | 122 ++++++++++++
 tb/tb_mux_nx1_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_pipe_if.sv
// rtl/mux_nx1_pipe_if.sv - valid/ready bus bundle for mux_nx1_pipe
`timescale 1ns/1ps
interface mux_nx1_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N:1 registered mux with 2-entry skid buffer
// Optional sticky out-of-range select flag: define MUX_SEL_CHECK_EN.
`timescale 1ns/1ps
module mux_nx1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_nx1_pipe_if.slave bus
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic          sel_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   sel_data;
  logic               in_xfer;
  logic               out_xfer;

  // Out-of-range selects fall through to the last input.
  always_comb begin
    sel_data = bus.in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.in_sel == SEL_W'(i)) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_data_d = sel_data;
          state_d     = FULL1;
        end
      end
      FULL1: begin
        if (in_xfer && out_xfer) begin
          main_data_d = sel_data;
        end else if (in_xfer) begin
          skid_data_d = sel_data;
          state_d     = FULL2;
        end else if (out_xfer) begin
          state_d     = EMPTY;
        end
      end
      FULL2: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          state_d     = FULL1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d  = (state_d != FULL2);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;
  logic sel_oor;

  assign sel_oor = (32'(bus.in_sel) >= 32'(NUM_IN));

  always_comb begin
    sel_err_d = sel_err_q | (in_xfer & sel_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - directed and scoreboard bench for mux_nx1_pipe
`timescale 1ns/1ps
module tb_mux_nx1_pipe;

  localparam int NBEATS = 10000;
  localparam int CYCLIM = 60000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if4 ();
  mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) if3 ();

`ifdef MUX_SEL_CHECK_EN
  logic sel_err4;
  logic sel_err3;
`endif

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_mux4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if4.slave)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err4)
`endif
  );

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_mux3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if3.slave)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_sel(input logic [127:0] d, input logic [1:0] s, input int nin);
    int idx;
    idx = (int'(s) >= nin) ? nin - 1 : int'(s);
    return d[idx*32 +: 32];
  endfunction

  logic [31:0] q[$];
  logic [31:0] exp_w;
  logic [127:0] rdata;
  int rx, tx, cyc;
  bit acc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    if4.in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    if4.in_sel = 2'd0;
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    if3.in_data = {32'hDEADBEEF, 32'hBBBBBBBB, 32'hAAAAAAAA};
    if3.in_sel = 2'd0;
    if3.in_valid = 1'b0;
    if3.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", {31'b0, if4.out_valid}, 32'd0);
    check("rst_out_data", if4.out_data, 32'h0);
    check("rst_in_ready", {31'b0, if4.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Select sweep, one beat per cycle.
    if4.in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if4.in_sel = 2'(s);
      tick();
      check("sweep_data", if4.out_data, 32'h11111111 * (s + 1));
      check("sweep_valid", {31'b0, if4.out_valid}, 32'd1);
      check("sweep_in_ready", {31'b0, if4.in_ready}, 32'd1);
    end
    if4.in_valid = 1'b0;
    tick();
    check("empty_valid", {31'b0, if4.out_valid}, 32'd0);
    check("empty_hold", if4.out_data, 32'h44444444);

    // Backpressure: A (sel1) then B (sel2), then C waits behind a full skid.
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1;
    if4.in_sel = 2'd1;
    tick();
    check("bp_a", if4.out_data, 32'h22222222);
    check("bp_ready_a", {31'b0, if4.in_ready}, 32'd1);
    if4.in_sel = 2'd2;
    tick();
    check("bp_a_hold", if4.out_data, 32'h22222222);
    check("bp_ready_b", {31'b0, if4.in_ready}, 32'd0);
    if4.in_sel = 2'd0;
    tick();
    check("bp_stall_data", if4.out_data, 32'h22222222);
    check("bp_stall_ready", {31'b0, if4.in_ready}, 32'd0);
    if4.out_ready = 1'b1;
    tick();
    check("bp_b", if4.out_data, 32'h33333333);
    check("bp_b_valid", {31'b0, if4.out_valid}, 32'd1);
    check("bp_ready_again", {31'b0, if4.in_ready}, 32'd1);
    tick();
    check("bp_c", if4.out_data, 32'h11111111);
    if4.in_valid = 1'b0;
    tick();
    check("bp_drained", {31'b0, if4.out_valid}, 32'd0);

    // Simultaneous in/out transfer while holding one beat.
    if4.in_valid = 1'b1;
    if4.in_sel = 2'd2;
    tick();
    if4.in_sel = 2'd3;
    tick();
    check("sim_data", if4.out_data, 32'h44444444);
    check("sim_in_ready", {31'b0, if4.in_ready}, 32'd1);
    if4.in_valid = 1'b0;
    tick();

    // Reset in the middle of a stalled transfer.
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1;
    if4.in_sel = 2'd1;
    tick();
    tick();
    check("pre_rst_ready", {31'b0, if4.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, if4.out_valid}, 32'd0);
    check("mid_rst_data", if4.out_data, 32'h0);
    check("mid_rst_ready", {31'b0, if4.in_ready}, 32'd1);
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {31'b0, if4.out_valid}, 32'd0);

    // Three inputs, out-of-range select maps to input 2.
`ifdef MUX_SEL_CHECK_EN
    check("sel_err_init", {31'b0, sel_err3}, 32'd0);
`endif
    if3.in_valid = 1'b1;
    if3.in_sel = 2'd1;
    tick();
    check("n3_sel1", if3.out_data, 32'hBBBBBBBB);
`ifdef MUX_SEL_CHECK_EN
    check("sel_err_inrange", {31'b0, sel_err3}, 32'd0);
`endif
    if3.in_sel = 2'd3;
    tick();
    check("n3_sel3", if3.out_data, 32'hDEADBEEF);
`ifdef MUX_SEL_CHECK_EN
    check("sel_err_set", {31'b0, sel_err3}, 32'd1);
`endif
    if3.in_sel = 2'd0;
    tick();
    check("n3_sel0", if3.out_data, 32'hAAAAAAAA);
    if3.in_valid = 1'b0;
    repeat (3) tick();
`ifdef MUX_SEL_CHECK_EN
    check("sel_err_sticky", {31'b0, sel_err3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("sel_err_rst", {31'b0, sel_err3}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Random valid/ready with an in-order scoreboard.
    rx = 0;
    tx = 0;
    cyc = 0;
    if4.in_valid = 1'b0;
    while (rx < NBEATS && cyc < CYCLIM) begin
      if (if4.out_valid && if4.out_ready) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
        check("rand_order", if4.out_data, exp_w);
        rx++;
      end
      acc = if4.in_valid && if4.in_ready;
      if (acc) begin
        q.push_back(ref_sel(if4.in_data, if4.in_sel, 4));
        tx++;
      end
      tick();
      cyc++;
      if (!if4.in_valid || acc) begin
        if (tx < NBEATS && ($urandom % 4) != 0) begin
          rdata = {$urandom, $urandom, $urandom, $urandom};
          if4.in_data = rdata;
          if4.in_sel = 2'($urandom_range(0, 3));
          if4.in_valid = 1'b1;
        end else begin
          if4.in_valid = 1'b0;
        end
      end
      if4.out_ready = (($urandom % 4) != 0);
    end
    check("rand_beats", rx, NBEATS);
    check("rand_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
